// File: rtl/dalu_ce_arb_if.sv
// Engine-result / E-stage mux bundle between the custom engines, decode and the ALU result mux.
// The arbiter takes the slave view; the engine and decode side takes the master view.
interface dalu_ce_arb_if;
   logic        CLMI_RHOLD;
   logic        CE_SLOT_P;
   logic        CE0_VLD_P;
   logic [31:0] CE0_RES_P;
   logic        CE1_VLD_P;
   logic [31:0] CE1_RES_P;
   logic        CE0_RDY;
   logic        CE1_RDY;
   logic        CE0_SEL_E_R;
   logic        CE1_SEL_E_R;
   logic [31:0] CE0_RES_E;
   logic [31:0] CE1_RES_E;
   logic        CE_STALL_P;
   logic        CE_OVF;

   modport slave (
      input  CLMI_RHOLD, CE_SLOT_P,
      input  CE0_VLD_P, CE0_RES_P, CE1_VLD_P, CE1_RES_P,
      output CE0_RDY, CE1_RDY, CE0_SEL_E_R, CE1_SEL_E_R,
      output CE0_RES_E, CE1_RES_E, CE_STALL_P, CE_OVF
   );

   modport master (
      output CLMI_RHOLD, CE_SLOT_P,
      output CE0_VLD_P, CE0_RES_P, CE1_VLD_P, CE1_RES_P,
      input  CE0_RDY, CE1_RDY, CE0_SEL_E_R, CE1_SEL_E_R,
      input  CE0_RES_E, CE1_RES_E, CE_STALL_P, CE_OVF
   );
endinterface

// File: rtl/dalu_ce_arb.sv
// Round-robin arbiter of two one-entry engine result buffers into free E-stage writeback slots.
// Latency VLD->SEL 2 edges, slot->SEL 1 edge; RDY low while a buffer is full, CE_STALL_P requests a bubble.
module dalu_ce_arb #(
   parameter int WAIT_MAX = 8,
   parameter int AGE_W    = 4
) (
   input  logic          SYSCLK,
   input  logic          RESET_D1_R,
   dalu_ce_arb_if.slave  ce
);

   localparam logic [AGE_W-1:0] AGE_SAT = '1;
   localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(WAIT_MAX);

   logic             r_pend0, r_pend1;
   logic             r_last;
   logic             r_sel0, r_sel1;
   logic             r_ovf;
   logic [AGE_W-1:0] r_age0, r_age1;
   logic [31:0]      r_buf0, r_buf1;
   logic [31:0]      r_res0, r_res1;

   logic w_run;
   logic w_gnt0, w_gnt1;
   logic w_cap0, w_cap1;
   logic w_ovf;

   // r_last names the engine granted most recently; on contention the other one wins.
   assign w_run  = ~ce.CLMI_RHOLD & ce.CE_SLOT_P;
   assign w_gnt0 = w_run & r_pend0 & (~r_pend1 | r_last);
   assign w_gnt1 = w_run & r_pend1 & (~r_pend0 | ~r_last);
   assign w_cap0 = ce.CE0_VLD_P & ~r_pend0;
   assign w_cap1 = ce.CE1_VLD_P & ~r_pend1;
   assign w_ovf  = (ce.CE0_VLD_P & r_pend0) | (ce.CE1_VLD_P & r_pend1);

   always_ff @(posedge SYSCLK) begin
      if (RESET_D1_R) begin
         r_pend0 <= 1'b0;
         r_pend1 <= 1'b0;
         r_last  <= 1'b1;
         r_sel0  <= 1'b0;
         r_sel1  <= 1'b0;
         r_ovf   <= 1'b0;
         r_age0  <= '0;
         r_age1  <= '0;
         r_buf0  <= '0;
         r_buf1  <= '0;
         r_res0  <= '0;
         r_res1  <= '0;
      end else begin
         // Capture and grant of one engine are exclusive: capture needs an empty buffer, grant a full one.
         if (w_cap0) begin
            r_buf0  <= ce.CE0_RES_P;
            r_pend0 <= 1'b1;
            r_age0  <= '0;
         end else if (w_gnt0) begin
            r_pend0 <= 1'b0;
            r_age0  <= '0;
         end else if (r_pend0 && !ce.CLMI_RHOLD && r_age0 != AGE_SAT) begin
            r_age0  <= r_age0 + AGE_W'(1);
         end

         if (w_cap1) begin
            r_buf1  <= ce.CE1_RES_P;
            r_pend1 <= 1'b1;
            r_age1  <= '0;
         end else if (w_gnt1) begin
            r_pend1 <= 1'b0;
            r_age1  <= '0;
         end else if (r_pend1 && !ce.CLMI_RHOLD && r_age1 != AGE_SAT) begin
            r_age1  <= r_age1 + AGE_W'(1);
         end

         if (!ce.CLMI_RHOLD) begin
            r_sel0 <= w_gnt0;
            r_sel1 <= w_gnt1;
            if (w_gnt0) r_res0 <= r_buf0;
            if (w_gnt1) r_res1 <= r_buf1;
            if (w_gnt0 || w_gnt1) r_last <= w_gnt1;
         end

         if (w_ovf) r_ovf <= 1'b1;
      end
   end

   assign ce.CE0_RDY     = ~r_pend0;
   assign ce.CE1_RDY     = ~r_pend1;
   assign ce.CE0_SEL_E_R = r_sel0;
   assign ce.CE1_SEL_E_R = r_sel1;
   assign ce.CE0_RES_E   = r_res0;
   assign ce.CE1_RES_E   = r_res1;
   assign ce.CE_OVF      = r_ovf;
   assign ce.CE_STALL_P  = (r_pend0 & (r_age0 >= AGE_LIM)) | (r_pend1 & (r_age1 >= AGE_LIM));

endmodule

// File: tb/tb_dalu_ce_arb.sv
// Bench for dalu_ce_arb: directed vector table, hand sequences for aging/hold/reset, and a
// randomized phase whose delivered results are checked against per-engine expected-data queues.
module tb_dalu_ce_arb;

   logic SYSCLK;
   logic RESET_D1_R;

   dalu_ce_arb_if bus ();

   dalu_ce_arb #(.WAIT_MAX(8), .AGE_W(4)) dut (
      .SYSCLK     (SYSCLK),
      .RESET_D1_R (RESET_D1_R),
      .ce         (bus)
   );

   initial begin
      SYSCLK = 1'b0;
      forever #5 SYSCLK = ~SYSCLK;
   end

   typedef struct {
      logic        rst, hold, slot, v0;
      logic [31:0] d0;
      logic        v1;
      logic [31:0] d1;
      logic        rdy0, rdy1, sel0, sel1;
      logic [31:0] res0, res1;
      logic        stall, ovf;
   } vec_t;

   vec_t        vecs[17];
   int          n_chk;
   int          n_fail;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   function automatic vec_t mk(logic rst, logic hold, logic slot, logic v0, logic [31:0] d0,
                               logic v1, logic [31:0] d1, logic rdy0, logic rdy1,
                               logic sel0, logic sel1, logic [31:0] res0, logic [31:0] res1,
                               logic stall, logic ovf);
      vec_t v;
      v.rst = rst; v.hold = hold; v.slot = slot; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
      v.rdy0 = rdy0; v.rdy1 = rdy1; v.sel0 = sel0; v.sel1 = sel1;
      v.res0 = res0; v.res1 = res1; v.stall = stall; v.ovf = ovf;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic hold, input logic slot, input logic v0,
                        input logic [31:0] d0, input logic v1, input logic [31:0] d1);
      RESET_D1_R     = rst;
      bus.CLMI_RHOLD = hold;
      bus.CE_SLOT_P  = slot;
      bus.CE0_VLD_P  = v0;
      bus.CE0_RES_P  = d0;
      bus.CE1_VLD_P  = v1;
      bus.CE1_RES_P  = d1;
   endtask

   task automatic tick();
      @(posedge SYSCLK);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
   endtask

   task automatic slot_cycle();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
   endtask

   // A SEL seen after a non-held edge is a fresh grant and must carry the oldest queued result.
   task automatic sb_sample(input logic hold_applied);
      chk("sel_exclusive", {31'h0, bus.CE0_SEL_E_R & bus.CE1_SEL_E_R}, 32'h0);
      if (!hold_applied && bus.CE0_SEL_E_R) begin
         if (q0.size() == 0) chk("sb0_unexpected_grant", 32'h1, 32'h0);
         else chk("sb0_data", bus.CE0_RES_E, q0.pop_front());
      end
      if (!hold_applied && bus.CE1_SEL_E_R) begin
         if (q1.size() == 0) chk("sb1_unexpected_grant", 32'h1, 32'h0);
         else chk("sb1_data", bus.CE1_RES_E, q1.pop_front());
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

      vecs[0]  = mk(1,0,0, 0,32'h0,        0,32'h0,   1,1, 0,0, 32'h0,        32'h0,   0,0);
      vecs[1]  = mk(0,0,0, 1,32'h1234_5678,0,32'h0,   0,1, 0,0, 32'h0,        32'h0,   0,0);
      vecs[2]  = mk(0,0,1, 0,32'h0,        0,32'h0,   1,1, 1,0, 32'h1234_5678,32'h0,   0,0);
      vecs[3]  = mk(0,0,0, 0,32'h0,        0,32'h0,   1,1, 0,0, 32'h1234_5678,32'h0,   0,0);
      vecs[4]  = mk(1,0,0, 0,32'h0,        0,32'h0,   1,1, 0,0, 32'h0,        32'h0,   0,0);
      vecs[5]  = mk(0,0,0, 1,32'hA,        1,32'hB,   0,0, 0,0, 32'h0,        32'h0,   0,0);
      vecs[6]  = mk(0,0,1, 0,32'h0,        0,32'h0,   1,0, 1,0, 32'hA,        32'h0,   0,0);
      vecs[7]  = mk(0,0,1, 0,32'h0,        0,32'h0,   1,1, 0,1, 32'hA,        32'hB,   0,0);
      vecs[8]  = mk(0,0,1, 0,32'h0,        0,32'h0,   1,1, 0,0, 32'hA,        32'hB,   0,0);
      vecs[9]  = mk(0,0,0, 1,32'hC,        1,32'hD,   0,0, 0,0, 32'hA,        32'hB,   0,0);
      vecs[10] = mk(0,0,1, 0,32'h0,        0,32'h0,   1,0, 1,0, 32'hC,        32'hB,   0,0);
      vecs[11] = mk(0,0,1, 0,32'h0,        0,32'h0,   1,1, 0,1, 32'hC,        32'hD,   0,0);
      vecs[12] = mk(0,0,0, 1,32'h1111,     0,32'h0,   0,1, 0,0, 32'hC,        32'hD,   0,0);
      vecs[13] = mk(0,0,0, 1,32'h2222,     0,32'h0,   0,1, 0,0, 32'hC,        32'hD,   0,1);
      vecs[14] = mk(0,0,1, 0,32'h0,        0,32'h0,   1,1, 1,0, 32'h1111,     32'hD,   0,1);
      vecs[15] = mk(0,0,0, 0,32'h0,        0,32'h0,   1,1, 0,0, 32'h1111,     32'hD,   0,1);
      vecs[16] = mk(1,0,0, 0,32'h0,        0,32'h0,   1,1, 0,0, 32'h0,        32'h0,   0,0);

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].rst, vecs[i].hold, vecs[i].slot, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
         tick();
         chk($sformatf("v%0d rdy0", i),  {31'h0, bus.CE0_RDY},     {31'h0, vecs[i].rdy0});
         chk($sformatf("v%0d rdy1", i),  {31'h0, bus.CE1_RDY},     {31'h0, vecs[i].rdy1});
         chk($sformatf("v%0d sel0", i),  {31'h0, bus.CE0_SEL_E_R}, {31'h0, vecs[i].sel0});
         chk($sformatf("v%0d sel1", i),  {31'h0, bus.CE1_SEL_E_R}, {31'h0, vecs[i].sel1});
         chk($sformatf("v%0d res0", i),  bus.CE0_RES_E,            vecs[i].res0);
         chk($sformatf("v%0d res1", i),  bus.CE1_RES_E,            vecs[i].res1);
         chk($sformatf("v%0d stall", i), {31'h0, bus.CE_STALL_P},  {31'h0, vecs[i].stall});
         chk($sformatf("v%0d ovf", i),   {31'h0, bus.CE_OVF},      {31'h0, vecs[i].ovf});
      end

      // Aging of a single buffer: stall rises exactly when age reaches 8.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0, 32'h0);
      tick();
      for (int k = 1; k <= 8; k++) begin
         idle();
         chk($sformatf("stall_age%0d", k), {31'h0, bus.CE_STALL_P}, (k >= 8) ? 32'h1 : 32'h0);
      end
      slot_cycle();
      chk("stall_grant_sel0", {31'h0, bus.CE0_SEL_E_R}, 32'h1);
      chk("stall_grant_res0", bus.CE0_RES_E, 32'h55);
      chk("stall_drop", {31'h0, bus.CE_STALL_P}, 32'h0);

      // Both buffers aged: stall needs two slots to clear.
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h60, 1'b1, 32'h61);
      tick();
      for (int k = 0; k < 8; k++) idle();
      chk("stall_both", {31'h0, bus.CE_STALL_P}, 32'h1);
      slot_cycle();
      chk("stall_both_g0", {31'h0, bus.CE0_SEL_E_R}, 32'h1);
      chk("stall_both_still", {31'h0, bus.CE_STALL_P}, 32'h1);
      slot_cycle();
      chk("stall_both_g1", bus.CE1_RES_E, 32'h61);
      chk("stall_both_clear", {31'h0, bus.CE_STALL_P}, 32'h0);

      // Hold freezes selection, data, round-robin state and ages.
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b1, 32'hBEEF);
      tick();
      slot_cycle();
      chk("hold_pre_sel0", {31'h0, bus.CE0_SEL_E_R}, 32'h1);
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
         tick();
         chk($sformatf("hold%0d_sel", k), {30'h0, bus.CE0_SEL_E_R, bus.CE1_SEL_E_R}, 32'h2);
         chk($sformatf("hold%0d_res0", k), bus.CE0_RES_E, 32'h77);
         chk($sformatf("hold%0d_rdy1", k), {31'h0, bus.CE1_RDY}, 32'h0);
         chk($sformatf("hold%0d_stall", k), {31'h0, bus.CE_STALL_P}, 32'h0);
      end
      slot_cycle();
      chk("hold_rel_sel", {30'h0, bus.CE0_SEL_E_R, bus.CE1_SEL_E_R}, 32'h1);
      chk("hold_rel_res1", bus.CE1_RES_E, 32'hBEEF);

      // Reset while both buffers pend and CE1 is selected, with an illegal VLD and a slot present.
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 32'h11);
      tick();
      slot_cycle();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h21);
      tick();
      chk("mid_pre_sel1", {31'h0, bus.CE1_SEL_E_R}, 32'h1);
      chk("mid_pre_rdy", {30'h0, bus.CE0_RDY, bus.CE1_RDY}, 32'h0);
      drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 1'b1, 32'h31);
      tick();
      chk("mid_rst_sel", {30'h0, bus.CE0_SEL_E_R, bus.CE1_SEL_E_R}, 32'h0);
      chk("mid_rst_rdy", {30'h0, bus.CE0_RDY, bus.CE1_RDY}, 32'h3);
      chk("mid_rst_res0", bus.CE0_RES_E, 32'h0);
      chk("mid_rst_res1", bus.CE1_RES_E, 32'h0);
      chk("mid_rst_flags", {30'h0, bus.CE_STALL_P, bus.CE_OVF}, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h41);
      tick();
      slot_cycle();
      chk("post_rst_rr_sel0", {30'h0, bus.CE0_SEL_E_R, bus.CE1_SEL_E_R}, 32'h2);
      chk("post_rst_rr_res0", bus.CE0_RES_E, 32'h40);

      // Randomized traffic checked through the expected-data queues.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic        h, s, v0, v1;
         logic [31:0] d0, d1;
         h  = ($urandom_range(3) == 0);
         s  = 1'($urandom_range(1));
         v0 = bus.CE0_RDY & 1'($urandom_range(1));
         v1 = bus.CE1_RDY & 1'($urandom_range(1));
         d0 = $urandom;
         d1 = $urandom;
         if (v0) q0.push_back(d0);
         if (v1) q1.push_back(d1);
         drive(1'b0, h, s, v0, d0, v1, d1);
         tick();
         sb_sample(h);
      end
      for (int c = 0; c < 4; c++) begin
         slot_cycle();
         sb_sample(1'b0);
      end
      chk("sb0_drained", q0.size(), 32'h0);
      chk("sb1_drained", q1.size(), 32'h0);
      chk("rand_no_ovf", {31'h0, bus.CE_OVF}, 32'h0);
      chk("rand_rdy_idle", {30'h0, bus.CE0_RDY, bus.CE1_RDY}, 32'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
